seq_mul: RTL and testbench

//  Parametrised iterative shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH.

---
 rtl/seq_mul_pkg.sv | 22 ++
 rtl/seq_mul_neg.sv | 20 ++
 rtl/seq_mul.sv | 126 ++++++++++++
 tb/tb_seq_mul.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/seq_mul_pkg.sv
// ============================================================================
// Module      : seq_mul_pkg
// Description : Shared FSM encodings and default sizing for the iterative
//               multipliers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_mul_pkg;

    localparam int C_DEF_WIDTH = 16;
    localparam int C_DEF_CNT_W = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/seq_mul_neg.sv
// ============================================================================
// Module      : seq_mul_neg
// Description : Conditional two's-complement negate, WIDTH bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_mul_neg #(
    parameter int WIDTH = 16
) (
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    assign dout = en ? (~din + WIDTH'(1)) : din;

endmodule

`default_nettype wire

// File: rtl/seq_mul.sv
// ============================================================================
// Module      : seq_mul
// Description : Iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH,
//               signed/unsigned, valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_mul
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = C_DEF_WIDTH,
    parameter int CNT_W = C_DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     ina,
    input  logic [WIDTH-1:0]     inb,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out
);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH - 1);

    state_t               r_state;
    logic [CNT_W-1:0]     r_count;
    logic [WIDTH-1:0]     r_mcand;
    logic [2*WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic                 r_neg;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [2*WIDTH-1:0]   r_out;

    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic [2*WIDTH-1:0]   w_result;

    // Magnitude of the most negative operand is 2**(WIDTH-1), which still
    // fits the unsigned WIDTH-bit register.
    seq_mul_neg #(.WIDTH(WIDTH)) u_neg_a (
        .en   (is_signed & ina[WIDTH-1]),
        .din  (ina),
        .dout (w_mag_a)
    );

    seq_mul_neg #(.WIDTH(WIDTH)) u_neg_b (
        .en   (is_signed & inb[WIDTH-1]),
        .din  (inb),
        .dout (w_mag_b)
    );

    assign w_acc_next = r_acc + (r_mcand[0] ? r_mplier : '0);

    seq_mul_neg #(.WIDTH(2 * WIDTH)) u_neg_res (
        .en   (r_neg),
        .din  (w_acc_next),
        .dout (w_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_neg       <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (in_valid && r_in_ready) begin
                        r_mcand    <= w_mag_a;
                        r_mplier   <= {{WIDTH{1'b0}}, w_mag_b};
                        r_neg      <= is_signed & (ina[WIDTH-1] ^ inb[WIDTH-1]);
                        r_acc      <= '0;
                        r_count    <= C_CNT_LAST;
                        r_in_ready <= 1'b0;
                        r_state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_acc    <= w_acc_next;
                    r_mplier <= r_mplier << 1;
                    r_mcand  <= r_mcand >> 1;
                    r_count  <= r_count - CNT_W'(1);
                    if (r_count == '0) begin
                        r_out       <= w_result;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Ready is raised on the drain edge so a new operand can
                    // only be taken on the following edge.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out       = r_out;

endmodule

`default_nettype wire

// File: tb/tb_seq_mul.sv
// ============================================================================
// Module      : tb_seq_mul
// Description : Directed self-checking bench for seq_mul, WIDTH=16 and WIDTH=8.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_mul;

    logic        clk;
    logic        rst_n;

    logic        in_valid16, in_ready16, sg16, out_valid16, out_ready16;
    logic [15:0] ina16, inb16;
    logic [31:0] out16;

    logic        in_valid8, in_ready8, sg8, out_valid8, out_ready8;
    logic [7:0]  ina8, inb8;
    logic [15:0] out8;

    int n_assert;
    int n_fail;

    seq_mul #(.WIDTH(16), .CNT_W(5)) u_dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .ina       (ina16),
        .inb       (inb16),
        .is_signed (sg16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .out       (out16)
    );

    seq_mul #(.WIDTH(8), .CNT_W(4)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .ina       (ina8),
        .inb       (inb8),
        .is_signed (sg8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .out       (out8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input int w);
        return (w == 16) ? in_ready16 : in_ready8;
    endfunction

    function automatic logic ov(input int w);
        return (w == 16) ? out_valid16 : out_valid8;
    endfunction

    function automatic logic [31:0] res(input int w);
        return (w == 16) ? out16 : {16'h0, out8};
    endfunction

    task automatic drive(input int w, input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic sg);
        if (w == 16) begin
            in_valid16 = v; ina16 = a; inb16 = b; sg16 = sg;
        end else begin
            in_valid8 = v; ina8 = a[7:0]; inb8 = b[7:0]; sg8 = sg;
        end
    endtask

    task automatic set_oready(input int w, input logic r);
        if (w == 16) out_ready16 = r;
        else         out_ready8  = r;
    endtask

    // Full transaction. Edge numbering: the acceptance edge is edge 1, so the
    // product must appear right after edge WIDTH+1 (17 for 16, 9 for 8).
    task automatic op(input int w, input logic [15:0] a, input logic [15:0] b, input logic sg,
                      input logic [31:0] exp, input string tag, input int hold);
        int  edges;
        logic stable;
        edges = 0;
        while (!rdy(w) && edges < 60) begin
            @(posedge clk); #1; edges++;
        end
        chk({tag, "_in_ready"}, rdy(w), 1'b1);
        drive(w, 1'b1, a, b, sg);
        @(posedge clk); #1;
        // Operand changes after acceptance must have no effect.
        drive(w, 1'b0, ~a, ~b, ~sg);
        edges = 1;
        while (!ov(w) && edges < 60) begin
            @(posedge clk); #1; edges++;
        end
        chk({tag, "_latency"}, edges, w + 1);
        chk({tag, "_out"}, res(w), exp);
        if (hold > 0) begin
            stable = 1'b1;
            for (int i = 0; i < hold; i++) begin
                drive(w, 1'b1, 16'h1234, 16'h5678, 1'b0);
                @(posedge clk); #1;
                if (!ov(w) || rdy(w) || res(w) !== exp) stable = 1'b0;
            end
            drive(w, 1'b0, 16'h0, 16'h0, 1'b0);
            chk({tag, "_hold_stable"}, stable, 1'b1);
        end
        set_oready(w, 1'b1);
        @(posedge clk); #1;
        set_oready(w, 1'b0);
        chk({tag, "_drain_valid"}, ov(w), 1'b0);
        chk({tag, "_drain_ready"}, rdy(w), 1'b1);
        chk({tag, "_out_kept"}, res(w), exp);
    endtask

    initial begin
        logic        seen;
        logic [7:0]  ra, rb;
        logic        rs;
        int          ma, mb, mp;

        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        drive(16, 1'b0, 16'h0, 16'h0, 1'b0);
        drive(8,  1'b0, 16'h0, 16'h0, 1'b0);
        set_oready(16, 1'b0);
        set_oready(8,  1'b0);

        #1;
        chk("reset_in_ready", in_ready16, 1'b0);
        chk("reset_out_valid", out_valid16, 1'b0);
        chk("reset_out", out16, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("post_reset_in_ready_low", in_ready16, 1'b0);
        @(posedge clk); #1;
        chk("first_clock_in_ready", in_ready16, 1'b1);

        op(16, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "u_ffff_ffff", 0);
        op(16, 16'h8000, 16'h8000, 1'b1, 32'h40000000, "s_8000_8000", 0);
        op(16, 16'hFFFD, 16'h0005, 1'b1, 32'hFFFFFFF1, "s_m3_5", 0);
        op(16, 16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, "s_m1_m1", 0);
        op(16, 16'h7FFF, 16'h8000, 1'b1, 32'hC0008000, "s_max_min", 0);
        op(16, 16'hFFFF, 16'h0000, 1'b1, 32'h00000000, "s_neg_zero", 0);
        op(16, 16'h1234, 16'h0010, 1'b0, 32'h00012340, "u_shift", 10);

        // Abort mid-BUSY: reset at BUSY cycle 8 must suppress the result.
        drive(16, 1'b1, 16'h00FF, 16'h0101, 1'b0);
        @(posedge clk); #1;
        drive(16, 1'b0, 16'h0, 16'h0, 1'b0);
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid16, 1'b0);
        chk("abort_out", out16, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid16) seen = 1'b1;
        end
        chk("abort_no_pulse", seen, 1'b0);
        chk("abort_out_after", out16, 32'h0);
        op(16, 16'h0003, 16'h0007, 1'b0, 32'h00000015, "after_abort", 0);

        op(8, 16'h00FF, 16'h00FF, 1'b0, 32'h0000FE01, "w8_u_ff_ff", 0);
        op(8, 16'h0080, 16'h0080, 1'b1, 32'h00004000, "w8_s_80_80", 0);
        op(8, 16'h00FF, 16'h00FF, 1'b1, 32'h00000001, "w8_s_m1_m1", 3);

        for (int n = 0; n < 200; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom);
            ma = rs ? int'($signed(ra)) : int'(ra);
            mb = rs ? int'($signed(rb)) : int'(rb);
            mp = ma * mb;
            op(8, {8'h0, ra}, {8'h0, rb}, rs, {16'h0, mp[15:0]}, "w8_rand", 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
